decode_writeback: RTL
=====================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 Parameter RSP_RESET, default 64'd0, is the value loaded into %rsp (register 4) on reset.
REQ-002 clk  input  1  rising-edge clock for all register-file writes.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 icode  input  4  instruction code from Fetch.
REQ-005 ifun  input  4  function code from Fetch.
REQ-006 rA  input  4  register-A field from Fetch.
REQ-007 rB  input  4  register-B field from Fetch.
REQ-008 cond_flag  input  1  condition result from Execute; gates the cmovXX write.
REQ-009 valE  input  64  ALU result from Execute.
REQ-010 valM  input  64  load data from Memory.
REQ-011 wb_en  input  1  writeback commit strobe, one cycle per retired instruction.
REQ-012 valA  output  64  operand A read from the register file.
REQ-013 valB  output  64  operand B read from the register file.
REQ-014 srcA, srcB, dstE, dstM  output  4 each  decoded register IDs (4'hF = none).
REQ-015 reg_err  output  1  illegal register field flag.

Function
REQ-016 The register file SHALL hold 15 64-bit registers, IDs 0-14; ID 4'hF is "none".
REQ-017 srcA SHALL be rA for icode 2, 4, 6 and A; 4 for icode 9 and B; F otherwise.
REQ-018 srcB SHALL be rB for icode 4, 5 and 6; 4 for icode 8, 9, A and B; F otherwise.
REQ-019 dstE SHALL be:
- rB for icode 3 and 6;
- rB for icode 2 when cond_flag=1, F when cond_flag=0;
- 4 for icode 8, 9, A and B;
- F otherwise.
REQ-020 dstM SHALL be rA for icode 5 and B; F otherwise.
REQ-021 valA and valB SHALL be combinational reads of srcA and srcB, returning 64'd0 when the ID is F.
REQ-022 On a rising edge with wb_en=1, the block SHALL write valE to dstE and valM to dstM; writes to F are discarded.
REQ-023 When dstE equals dstM and neither is F (popq %rsp), only valM SHALL be written.
REQ-024 With wb_en=0, the register file SHALL hold its contents.
REQ-025 A read in the same cycle as a write SHALL return the pre-edge value; the new value is visible from the next cycle.
REQ-026 Latency: decode is zero-cycle combinational; writeback takes one edge.
REQ-027 The block SHALL keep no state other than the 15 registers.

Reset
REQ-028 On rst_n=0, all registers SHALL clear to 64'd0 immediately, except %rsp, which loads RSP_RESET; this is independent of clk.
REQ-029 A write edge coinciding with rst_n=0 SHALL be ignored.
REQ-030 Decode outputs stay combinational during reset; reg_err SHALL follow REQ-031/032.

Configuration
REQ-031 With DECODE_REG_CHECK_EN defined, reg_err SHALL assert combinationally when a required field equals F:
- rA for icode 2, 4, 6, A, B;
- rB for icode 2, 3, 4, 6;
- while reg_err=1, all writes that edge SHALL be suppressed.
REQ-032 Without DECODE_REG_CHECK_EN, reg_err SHALL be tied 0 and writes proceed per REQ-022.

Verification
REQ-033 Reset with RSP_RESET=64'h200, then read icode=9 -> valA=valB=64'h200; a read of register 3 returns 0.
REQ-034 Write sequence:
- icode=3, rB=2, valE=64'd230, wb_en pulse -> next cycle, icode=6 rA=2 rB=2 gives valA=valB=230;
- icode=2, rB=5, cond_flag=0, wb_en pulse -> register 5 unchanged, dstE=F.
REQ-035 popq %rsp: icode=B, rA=4, valE=64'h208, valM=64'h55, wb_en -> %rsp=64'h55.
REQ-036 Drop rst_n mid-cycle after writing register 1=64'd7 -> valA for rA=1 reads 0 before the next edge.
REQ-037 With DECODE_REG_CHECK_EN: icode=6, rA=F, rB=1, wb_en pulse -> reg_err=1 and register 1 unchanged; without the macro -> reg_err=0 and register 1=valE.

Source files
------------

// File: rtl/decode_writeback.sv
`default_nettype none
// ============================================================================
// Module   : decode_writeback
// Purpose  : Decode and writeback stages of a Y86-64 style pipeline. The block
//            decodes the fetched fields into register IDs and reads operands.
//            It also owns the 15-entry register file that the writeback stage
//            updates.
//
// Ports    : clk        - rising-edge clock for register-file writes
//            rst_n      - asynchronous active-low reset
//            icode/ifun - instruction and function codes from Fetch
//            rA/rB      - register fields from Fetch
//            cond_flag  - Execute condition result; gates the cmovXX write
//            valE/valM  - ALU result and load data to be written back
//            wb_en      - writeback commit strobe
//            valA/valB  - operands read from the register file (0 for ID F)
//            srcA/srcB  - decoded source register IDs (4'hF = none)
//            dstE/dstM  - decoded destination register IDs (4'hF = none)
//            reg_err    - illegal register field flag
//
// Config   : DECODE_REG_CHECK_EN - when defined, a required rA/rB field equal
//            to F raises reg_err and blocks every write on that edge. When
//            undefined, reg_err is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module decode_writeback #(
  parameter logic [63:0] RSP_RESET = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cond_flag,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic        reg_err
);

  localparam logic [3:0] C_RNONE   = 4'hF;
  localparam logic [3:0] C_RSP     = 4'h4;

  localparam logic [3:0] C_RRMOVQ  = 4'h2;  // also cmovXX
  localparam logic [3:0] C_IRMOVQ  = 4'h3;
  localparam logic [3:0] C_RMMOVQ  = 4'h4;
  localparam logic [3:0] C_MRMOVQ  = 4'h5;
  localparam logic [3:0] C_OPQ     = 4'h6;
  localparam logic [3:0] C_CALL    = 4'h8;
  localparam logic [3:0] C_RET     = 4'h9;
  localparam logic [3:0] C_PUSHQ   = 4'hA;
  localparam logic [3:0] C_POPQ    = 4'hB;

  // ifun does not affect decode or writeback here.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  // --------------------------------------------------------------------------
  // Register ID decode (purely combinational)
  // --------------------------------------------------------------------------
  always_comb begin
    srcA = C_RNONE;
    srcB = C_RNONE;
    dstE = C_RNONE;
    dstM = C_RNONE;
    case (icode)
      C_RRMOVQ: begin
        srcA = rA;
        dstE = cond_flag ? rB : C_RNONE;
      end
      C_IRMOVQ: begin
        dstE = rB;
      end
      C_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      C_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      C_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      C_CALL: begin
        srcB = C_RSP;
        dstE = C_RSP;
      end
      C_RET: begin
        srcA = C_RSP;
        srcB = C_RSP;
        dstE = C_RSP;
      end
      C_PUSHQ: begin
        srcA = rA;
        srcB = C_RSP;
        dstE = C_RSP;
      end
      C_POPQ: begin
        srcA = C_RSP;
        srcB = C_RSP;
        dstE = C_RSP;
        dstM = rA;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Illegal register field check
  // --------------------------------------------------------------------------
`ifdef DECODE_REG_CHECK_EN
  logic ra_required;
  logic rb_required;

  always_comb begin
    ra_required = 1'b0;
    rb_required = 1'b0;
    case (icode)
      C_RRMOVQ: begin ra_required = 1'b1; rb_required = 1'b1; end
      C_IRMOVQ: begin rb_required = 1'b1; end
      C_RMMOVQ: begin ra_required = 1'b1; rb_required = 1'b1; end
      C_OPQ:    begin ra_required = 1'b1; rb_required = 1'b1; end
      C_PUSHQ:  begin ra_required = 1'b1; end
      C_POPQ:   begin ra_required = 1'b1; end
      default:  begin end
    endcase
  end

  assign reg_err = (ra_required && (rA == C_RNONE)) ||
                   (rb_required && (rB == C_RNONE));
`else
  assign reg_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Write enables
  // A popq %rsp produces dstE == dstM. In that case only the load value is
  // committed, so the E port is disabled whenever it aliases the M port.
  // --------------------------------------------------------------------------
  logic we_e;
  logic we_m;

  assign we_m = wb_en && !reg_err && (dstM != C_RNONE);
  assign we_e = wb_en && !reg_err && (dstE != C_RNONE) && (dstE != dstM);

  // --------------------------------------------------------------------------
  // Register file. Entry 15 of the read vector is the hard-wired "none" slot,
  // so that ID F reads 0 without a separate compare.
  // --------------------------------------------------------------------------
  logic [15:0][63:0] rd_vec;

  assign rd_vec[15] = 64'd0;

  for (genvar gi = 0; gi < 15; gi++) begin : g_reg
    localparam logic [3:0]  C_ID  = 4'(gi);
    localparam logic [63:0] C_RST = (gi == 4) ? RSP_RESET : 64'd0;

    logic [63:0] rf_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rf_q <= C_RST;
      end else if (we_m && (dstM == C_ID)) begin
        rf_q <= valM;
      end else if (we_e && (dstE == C_ID)) begin
        rf_q <= valE;
      end
    end

    assign rd_vec[gi] = rf_q;
  end

  // Reads return the current register contents. A same-cycle write therefore
  // becomes visible only after the edge.
  assign valA = rd_vec[srcA];
  assign valB = rd_vec[srcB];

endmodule
`default_nettype wire
